// File: rtl/key_toggle_latch.sv
// Eight-key debounce and toggle stage: synchronises raw buttons, debounces them,
// and flips one output bit per clean press, with a one-cycle press pulse per key.
module key_toggle_latch #(
    parameter int DEB_CNT = 4,
    parameter int CNT_W   = 4
) (
    input  logic       clk190hz,
    input  logic       rst,
    input  logic [7:0] key_raw,
    input  logic       clr,
    output logic [7:0] bits,
    output logic [7:0] key_evt,
    output logic       any_evt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [7:0]       s1_q, s1_d;
    logic [7:0]       s2_q, s2_d;
    logic [7:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [7:0]       bits_q, bits_d;
    logic [7:0]       key_evt_q, key_evt_d;
    logic             any_evt_q, any_evt_d;
    logic [7:0]       press;

    always_comb begin
        s1_d = key_raw;
        s2_d = s1_q;
    end

    // A key's stable state flips only after DEB_CNT consecutive disagreeing samples.
    always_comb begin
        stable_d = stable_q;
        press    = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = CNT_ZERO;
                press[i]    = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Clear wins over toggles on the same edge, but press pulses are still reported.
    always_comb begin
        bits_d    = clr ? 8'h00 : (bits_q ^ press);
        key_evt_d = press;
        any_evt_d = |press;
    end

    always_ff @(posedge clk190hz or negedge rst) begin
        if (!rst) begin
            s1_q      <= 8'h00;
            s2_q      <= 8'h00;
            stable_q  <= 8'h00;
            bits_q    <= 8'h00;
            key_evt_q <= 8'h00;
            any_evt_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            bits_q    <= bits_d;
            key_evt_q <= key_evt_d;
            any_evt_q <= any_evt_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bits    = bits_q;
    assign key_evt = key_evt_q;
    assign any_evt = any_evt_q;

endmodule

// File: tb/tb_key_toggle_latch.sv
// Bench for key_toggle_latch: directed scenarios plus random key activity,
// compared each cycle against a sample-history reference model.
module tb_key_toggle_latch;

    localparam int DEB = 4;

    logic       clk190hz = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] key_raw  = 8'h00;
    logic       clr      = 1'b0;
    logic [7:0] bits;
    logic [7:0] key_evt;
    logic       any_evt;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0] hist_q[$];
    logic [7:0] m_stab;
    int         m_run [8];
    logic [7:0] m_bits;
    logic [7:0] m_evt;
    logic       m_any;
    int         evt_count;

    always #5 clk190hz = ~clk190hz;

    key_toggle_latch #(.DEB_CNT(DEB), .CNT_W(4)) dut (
        .clk190hz (clk190hz),
        .rst      (rst),
        .key_raw  (key_raw),
        .clr      (clr),
        .bits     (bits),
        .key_evt  (key_evt),
        .any_evt  (any_evt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist_q.delete();
        m_stab = 8'h00;
        m_bits = 8'h00;
        m_evt  = 8'h00;
        m_any  = 1'b0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endtask

    // One active edge: the debouncer sees the key value sampled two edges earlier.
    task automatic model_edge(input logic [7:0] k, input logic c);
        logic [7:0] seen;
        logic [7:0] pr;
        seen = (hist_q.size() >= 2) ? hist_q[hist_q.size() - 2] : 8'h00;
        hist_q.push_back(k);
        if (hist_q.size() > 4) void'(hist_q.pop_front());
        pr = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (seen[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_stab[i] = seen[i];
                    m_run[i]  = 0;
                    if (seen[i]) pr[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_bits = c ? 8'h00 : (m_bits ^ pr);
        m_evt  = pr;
        m_any  = |pr;
    endtask

    task automatic tick(input logic [7:0] k, input logic c);
        key_raw = k;
        clr     = c;
        @(posedge clk190hz);
        model_edge(k, c);
        @(negedge clk190hz);
        chk("bits", bits, m_bits);
        chk("key_evt", key_evt, m_evt);
        chk("any_evt", {7'h00, any_evt}, {7'h00, m_any});
        if (key_evt != 8'h00) evt_count++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk190hz);
        rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < n; i++) begin
            chk("rst_bits", bits, 8'h00);
            chk("rst_evt", key_evt, 8'h00);
            chk("rst_any", {7'h00, any_evt}, 8'h00);
            @(negedge clk190hz);
        end
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] k;
        logic [7:0] bounce;
        model_reset();
        evt_count = 0;
        #1;

        // reset then idle
        do_reset(3);
        for (int i = 0; i < 50; i++) tick(8'h00, 1'b0);
        chk("idle_no_evt", evt_count[7:0], 8'h00);

        // clean press on key 0, exact latency
        for (int i = 0; i < 20; i++) begin
            tick(8'h01, 1'b0);
            if (i == 4) chk("press0_pre_bits", bits, 8'h00);
            if (i == 5) begin
                chk("press0_bits", bits, 8'h01);
                chk("press0_evt", key_evt, 8'h01);
            end
            if (i == 6) chk("press0_evt_clear", key_evt, 8'h00);
        end
        for (int i = 0; i < 10; i++) tick(8'h00, 1'b0);
        for (int i = 0; i < 10; i++) tick(8'h01, 1'b0);
        chk("press0_again_bits", bits, 8'h00);
        for (int i = 0; i < 10; i++) tick(8'h00, 1'b0);

        // bounce rejection on key 2
        bounce = 8'b0010_1101;
        evt_count = 0;
        for (int i = 0; i < 6; i++) begin
            tick({5'b0, bounce[5 - i], 2'b0}, 1'b0);
            chk("bounce_quiet", key_evt, 8'h00);
        end
        for (int i = 0; i < 12; i++) tick(8'h04, 1'b0);
        chk("bounce_one_evt", evt_count[7:0], 8'h01);
        chk("bounce_bits", bits, 8'h04);
        for (int i = 0; i < 10; i++) tick(8'h00, 1'b0);

        // short glitch on key 7
        evt_count = 0;
        for (int i = 0; i < 3; i++) tick(8'h80, 1'b0);
        for (int i = 0; i < 10; i++) tick(8'h00, 1'b0);
        chk("glitch_no_evt", evt_count[7:0], 8'h00);
        chk("glitch_bits", bits, 8'h04);

        // bring bits to 0F, then simultaneous keys 4 and 5
        for (int i = 0; i < 8; i++) tick(8'h0B, 1'b0);
        for (int i = 0; i < 8; i++) tick(8'h00, 1'b0);
        chk("setup_0f", bits, 8'h0F);
        for (int i = 0; i < 8; i++) begin
            tick(8'h30, 1'b0);
            if (i == 5) begin
                chk("simul_evt", key_evt, 8'h30);
                chk("simul_any", {7'h00, any_evt}, 8'h01);
                chk("simul_bits", bits, 8'h3F);
            end
        end
        for (int i = 0; i < 8; i++) tick(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(8'h30, (i == 5));
            if (i == 5) begin
                chk("clr_bits", bits, 8'h00);
                chk("clr_evt", key_evt, 8'h30);
            end
        end
        for (int i = 0; i < 8; i++) tick(8'h00, 1'b0);

        // reset mid-debounce with key 1 held
        tick(8'h02, 1'b0);
        tick(8'h02, 1'b0);
        key_raw = 8'h02;
        do_reset(3);
        for (int i = 0; i < 10; i++) begin
            tick(8'h02, 1'b0);
            if (i == DEB) chk("rst_mid_pre", bits, 8'h00);
            if (i == DEB + 1) chk("rst_mid_bits", bits, 8'h02);
        end

        // random key activity with occasional clear and reset
        k = 8'h00;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 9) == 0) k[i] = ~k[i];
            end
            if ($urandom_range(0, 199) == 0) begin
                key_raw = k;
                do_reset($urandom_range(1, 3));
            end
            tick(k, ($urandom_range(0, 24) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_toggle_latch.md
Name: key_toggle_latch

Overview:
- Upstream input stage for the BCD nibble-to-display path.
- Turns eight raw, bouncy, active-high push buttons into two stable 4-bit nibbles, one bit per button.
- Each clean press toggles its bit, so an operator can dial any 0..15 value per nibble.
- Outputs drive the but1..but8 inputs of the nibble-conversion stage, all in the clk190hz domain.

Parameters:
- DEB_CNT, 4, consecutive clk190hz samples a synchronised key must disagree with its stable state before the stable state flips (about 21 ms at 190 Hz); legal range 1..15.
- CNT_W, 4, debounce counter width; must satisfy 2^CNT_W > DEB_CNT.

Ports:
- clk190hz, input, 1: sole clock, about 190 Hz scan clock.
- rst, input, 1: asynchronous, active-low reset.
- key_raw, input, 8: raw buttons, bit0=but1 .. bit7=but8; 1 = pressed; asynchronous to clk190hz.
- clr, input, 1: synchronous active-high clear of toggle state.
- bits, output, 8: toggle state; bits[3:0] feed nibble 1 (but4..but1), bits[7:4] feed nibble 2 (but8..but5).
- key_evt, output, 8: one-cycle pulse per key on each debounced press (0->1).
- any_evt, output, 1: OR of key_evt, registered on the same edge as key_evt.

Behaviour:
- Reset (rst=0, async): sync stages, stable states, counters, bits, key_evt and any_evt all go to 0. Deassertion takes effect at the next clk190hz edge.
- Synchroniser: 2 flops per key (s1, s2). key_raw is sampled into s1 at edge n and reaches s2 at edge n+1.
- Debouncer, per key, each edge:
  - If s2 == stable: counter <= 0.
  - Else if counter == DEB_CNT-1: stable <= s2, counter <= 0.
  - Else: counter <= counter+1.
  - Any single sample of s2 equal to stable restarts the count. A glitch shorter than DEB_CNT s2 samples never changes stable.
- Press detect: on the edge where stable goes 0->1, for that key:
  - key_evt[i] <= 1 for exactly one cycle.
  - bits[i] <= ~bits[i].
- Release (1->0 stable transition): no event, bits unchanged.
- Latency: key_raw high and held, first sampled at edge 0 -> bits and key_evt update at edge DEB_CNT+1 (edge 5 for default).
- Keys are independent. Several keys maturing on the same edge each toggle and pulse on that edge.
- clr=1 at an edge: bits <= 0 (priority over any toggle on that edge). key_evt and any_evt still report presses maturing on that edge. Debouncer state is not touched.
- Holding a key produces exactly one event; a new event needs a debounced release followed by a debounced press.
- Reset asserted mid-debounce: count is discarded. After release, a still-held key is seen as a fresh press, which toggles its bit from 0 to 1 after DEB_CNT+1 edges.
- All outputs are registered; no combinational path from key_raw to outputs.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, key_raw=0 -> bits=8'h00, key_evt=0, any_evt=0 throughout; no pulses for 50 cycles after release.
- Clean press, key 0: key_raw=8'h01 from edge 0, held 20 cycles -> bits=8'h01 and key_evt=8'h01 at edge 5. key_evt back to 0 at edge 6. Release and press again -> bits=8'h00.
- Bounce rejection: key_raw[2] toggles 1,0,1,1,0,1 on successive edges, then steady 1 -> no event during bouncing. Exactly one event, bits[2]=1, 5 edges after the steady run begins.
- Short glitch: key_raw[7]=1 for 3 cycles (DEB_CNT=4) -> bits and key_evt unchanged.
- Simultaneous keys plus clear: with bits=8'h0F, press keys 4 and 5 together -> on the same edge key_evt=8'h30, any_evt=1, bits=8'h3F. Repeat the press with clr=1 on the maturing edge -> bits=8'h00, key_evt=8'h30.
- Reset mid-debounce: key_raw[1]=1, assert rst after 2 sampled cycles, release rst and keep the key held -> bits=8'h00 during reset; bits[1]=1 exactly DEB_CNT+1 edges after the first post-reset edge.
